// File: rtl/mem_arb_pkg.sv
// Shared definitions for the program/data RAM port arbiter: FSM state codes,
// owner codes and the requester bit positions used in the request/grant vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    // Bit positions of each requester inside the req/grant vectors
    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    // Map a one-hot (or empty) grant vector onto the owner code
    function automatic logic [1:0] grant_to_owner(input logic [1:0] grant);
        if (grant[REQ_DBG]) begin
            return OWN_DBG;
        end
        if (grant[REQ_CPU]) begin
            return OWN_CPU;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a debug lock. Purely combinational; the
// caller owns the last_grant register (1 = debug was granted most recently).
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Lock hands the memory to debug only; otherwise a tie goes to whoever lost last time
    always_comb begin
        grant = 2'b00;
        if (lock) begin
            grant[REQ_DBG] = req[REQ_DBG];
        end else if (req[REQ_CPU] && req[REQ_DBG]) begin
            if (last_grant) begin
                grant[REQ_CPU] = 1'b1;
            end else begin
                grant[REQ_DBG] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port synchronous RAM between the CPU datapath and the
// debug/loader port. Every access walks IDLE -> ISSUE -> DONE: requests are
// sampled and latched in IDLE, the RAM is strobed in ISSUE and the winner is
// acknowledged in DONE, where read data arrives from the RAM.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    state_t        state;
    state_t        state_next;
    logic [1:0]    grant;
    logic [1:0]    winner;
    logic          last_grant;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] cpu_hold;
    logic [DW-1:0] dbg_hold;

    rr_arbiter2 u_arb (
        .req        ({dbg_req, cpu_req}),
        .lock       (dbg_lock),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // State register; reset abandons any in-flight access without an ack
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the RAM strobe, acks and owner; strobes and acks are held off while rst is low
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        cpu_ack    = 1'b0;
        dbg_ack    = 1'b0;
        owner      = OWN_NONE;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_DONE;
                mem_en     = rst;
                mem_we     = rst & lat_we;
                owner      = winner;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                cpu_ack    = rst && (winner == OWN_CPU);
                dbg_ack    = rst && (winner == OWN_DBG);
                owner      = winner;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's command at the grant so requesters may change their inputs afterwards
    always_ff @(posedge clk) begin
        if (!rst) begin
            winner     <= OWN_NONE;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if ((state == ST_IDLE) && (|grant)) begin
            winner     <= grant_to_owner(grant);
            last_grant <= grant[REQ_DBG];
            lat_we     <= grant[REQ_DBG] ? dbg_we    : cpu_we;
            lat_addr   <= grant[REQ_DBG] ? dbg_addr  : cpu_addr;
            lat_wdata  <= grant[REQ_DBG] ? dbg_wdata : cpu_wdata;
        end
    end

    // Keep the last read result per requester so rdata stays stable between accesses
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_hold <= '0;
            dbg_hold <= '0;
        end else if ((state == ST_DONE) && !lat_we) begin
            if (winner == OWN_CPU) begin
                cpu_hold <= mem_rdata;
            end
            if (winner == OWN_DBG) begin
                dbg_hold <= mem_rdata;
            end
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign cpu_rdata = (cpu_ack && !lat_we) ? mem_rdata : cpu_hold;
    assign dbg_rdata = (dbg_ack && !lat_we) ? mem_rdata : dbg_hold;
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized two-requester run checked against a transaction-level model.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
    logic       cpu_ack, cpu_stall;
    logic [7:0] cpu_rdata;
    logic       dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [7:0] dbg_addr = 8'h00, dbg_wdata = 8'h00;
    logic       dbg_ack;
    logic [7:0] dbg_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic [1:0] owner;

    logic [7:0] ram    [256] = '{default: 8'h00};
    logic [7:0] shadow [256] = '{default: 8'h00};

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_lock  (dbg_lock),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (ram_rdata),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_rdata     <= ram[mem_addr];
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        dbg_lock = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (3) step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) step();
        n_checks++; if (cpu_ack !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
        n_checks++; if (dbg_ack !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_dbg_ack: got %b expected 0", dbg_ack); end
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_cpu_rdata: got %h expected 00", cpu_rdata); end
        n_checks++; if (dbg_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_dbg_rdata: got %h expected 00", dbg_rdata); end
        n_checks++; if (owner !== 2'b00)    begin n_fail++; $display("[TB] FAIL reset_owner: got %b expected 00", owner); end
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobe: got en=%b we=%b expected 0/0", mem_en, mem_we); end
        n_checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_mem_bus: got addr=%h wdata=%h expected 00/00", mem_addr, mem_wdata); end
        rst = 1'b1;
        step();
        n_checks++; if (owner !== 2'b00 || mem_en !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_release: got owner=%b en=%b stall=%b expected 00/0/0", owner, mem_en, cpu_stall); end
    endtask

    task automatic test_dbg_write_read();
        do_reset();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 8'h3A;
        step();
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL dbgwr_strobe: got en=%b we=%b expected 1/1", mem_en, mem_we); end
        n_checks++; if (mem_addr !== 8'h10 || mem_wdata !== 8'h3A) begin n_fail++; $display("[TB] FAIL dbgwr_bus: got addr=%h wdata=%h expected 10/3a", mem_addr, mem_wdata); end
        n_checks++; if (owner !== 2'b10 || dbg_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL dbgwr_issue: got owner=%b ack=%b expected 10/0", owner, dbg_ack); end
        step();
        n_checks++; if (dbg_ack !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL dbgwr_ack: got ack=%b en=%b expected 1/0", dbg_ack, mem_en); end
        shadow[8'h10] = 8'h3A;
        dbg_req = 1'b0;
        step();
        n_checks++; if (owner !== 2'b00) begin n_fail++; $display("[TB] FAIL dbgwr_idle_owner: got %b expected 00", owner); end
        dbg_req = 1'b1; dbg_we = 1'b0;
        step();
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL dbgrd_strobe: got en=%b we=%b expected 1/0", mem_en, mem_we); end
        step();
        n_checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 8'h3A) begin n_fail++; $display("[TB] FAIL dbgrd_done: got ack=%b rdata=%h expected 1/3a", dbg_ack, dbg_rdata); end
        n_checks++; if (cpu_rdata !== 8'h00 || cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL dbgrd_cpu_side: got rdata=%h ack=%b expected 00/0", cpu_rdata, cpu_ack); end
        dbg_req = 1'b0;
        repeat (2) step();
        n_checks++; if (dbg_rdata !== 8'h3A || dbg_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL dbgrd_hold: got rdata=%h ack=%b expected 3a/0", dbg_rdata, dbg_ack); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_own [11] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        int c_done = 0;
        int d_done = 0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
        for (int i = 0; i < 11; i++) begin
            step();
            n_checks++; if (owner !== exp_own[i]) begin n_fail++; $display("[TB] FAIL rr_owner[%0d]: got %b expected %b", i, owner, exp_own[i]); end
            if (cpu_ack) begin
                n_checks++; if (cpu_rdata !== shadow[8'h10]) begin n_fail++; $display("[TB] FAIL rr_cpu_rdata: got %h expected %h", cpu_rdata, shadow[8'h10]); end
                cpu_req = 1'b0; c_done++;
            end else if (!cpu_req && c_done < 2) begin
                cpu_req = 1'b1;
            end
            if (dbg_ack) begin
                n_checks++; if (dbg_rdata !== shadow[8'h20]) begin n_fail++; $display("[TB] FAIL rr_dbg_rdata: got %h expected %h", dbg_rdata, shadow[8'h20]); end
                dbg_req = 1'b0; d_done++;
            end else if (!dbg_req && d_done < 2) begin
                dbg_req = 1'b1;
            end
        end
        n_checks++; if (c_done != 2 || d_done != 2) begin n_fail++; $display("[TB] FAIL rr_ack_count: got cpu=%0d dbg=%0d expected 2/2", c_done, d_done); end
        clear_inputs();
        step();
    endtask

    task automatic test_lock_stall();
        bit got;
        do_reset();
        dbg_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
        for (int i = 0; i < 4; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40 + 8'(i); dbg_wdata = 8'($urandom);
            got = 1'b0;
            for (int c = 0; c < 4 && !got; c++) begin
                step();
                n_checks++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_cpu_stalled: got stall=%b ack=%b expected 1/0", cpu_stall, cpu_ack); end
                if (dbg_ack) got = 1'b1;
            end
            n_checks++; if (!got) begin n_fail++; $display("[TB] FAIL lock_dbg_ack: got no ack expected ack within 4 cycles"); end
            shadow[dbg_addr] = dbg_wdata;
            dbg_req = 1'b0;
            if (i == 3) dbg_lock = 1'b0;
            step();
            n_checks++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_cpu_gap: got stall=%b ack=%b expected 1/0", cpu_stall, cpu_ack); end
        end
        got = 1'b0;
        for (int c = 0; c < 2 && !got; c++) begin
            step();
            if (cpu_ack) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("[TB] FAIL unlock_cpu_ack: got no ack expected ack within 3 cycles"); end
        n_checks++; if (cpu_rdata !== shadow[8'h40]) begin n_fail++; $display("[TB] FAIL unlock_cpu_rdata: got %h expected %h", cpu_rdata, shadow[8'h40]); end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        int acks    = 0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (mem_en) begin
                strobes++;
                n_checks++; if (mem_addr !== 8'h20) begin n_fail++; $display("[TB] FAIL b2b_addr: got %h expected 20", mem_addr); end
            end
            if (cpu_ack) acks++;
            if (c == 4) cpu_req = 1'b0;
        end
        n_checks++; if (strobes != 2) begin n_fail++; $display("[TB] FAIL b2b_strobes: got %0d expected 2", strobes); end
        n_checks++; if (acks != 2)    begin n_fail++; $display("[TB] FAIL b2b_acks: got %0d expected 2", acks); end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h55; dbg_wdata = 8'hC3;
        repeat (2) step();
        n_checks++; if (dbg_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL rstiss_setup_ack: got %b expected 1", dbg_ack); end
        shadow[8'h55] = 8'hC3;
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1; dbg_wdata = 8'h99;
        step();
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("[TB] FAIL rstiss_pre: got en=%b expected 1", mem_en); end
        rst = 1'b0; dbg_req = 1'b0;
        #1;
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rstiss_gate: got en=%b we=%b expected 0/0", mem_en, mem_we); end
        step();
        n_checks++; if (dbg_ack !== 1'b0 || owner !== 2'b00) begin n_fail++; $display("[TB] FAIL rstiss_after: got ack=%b owner=%b expected 0/00", dbg_ack, owner); end
        rst = 1'b1;
        step();
        n_checks++; if (dbg_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rstiss_no_ack: got %b expected 0", dbg_ack); end
        dbg_req = 1'b1; dbg_we = 1'b0;
        repeat (2) step();
        n_checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 8'hC3) begin n_fail++; $display("[TB] FAIL rstiss_readback: got ack=%b rdata=%h expected 1/c3", dbg_ack, dbg_rdata); end
        dbg_req = 1'b0;
        step();
    endtask

    task automatic test_lock_midflight();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h41;
        step();
        n_checks++; if (owner !== 2'b01) begin n_fail++; $display("[TB] FAIL midlock_issue: got owner=%b expected 01", owner); end
        dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h42;
        step();
        n_checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== shadow[8'h41]) begin n_fail++; $display("[TB] FAIL midlock_cpu_done: got ack=%b rdata=%h expected 1/%h", cpu_ack, cpu_rdata, shadow[8'h41]); end
        repeat (2) step();
        n_checks++; if (owner !== 2'b10) begin n_fail++; $display("[TB] FAIL midlock_next_grant: got %b expected 10", owner); end
        step();
        n_checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== shadow[8'h42]) begin n_fail++; $display("[TB] FAIL midlock_dbg_done: got ack=%b rdata=%h expected 1/%h", dbg_ack, dbg_rdata, shadow[8'h42]); end
        dbg_req = 1'b0;
        repeat (2) step();
        n_checks++; if (owner !== 2'b00 || cpu_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL midlock_cpu_blocked: got owner=%b stall=%b expected 00/1", owner, cpu_stall); end
        dbg_lock = 1'b0;
        step();
        n_checks++; if (owner !== 2'b01) begin n_fail++; $display("[TB] FAIL midlock_release: got %b expected 01", owner); end
        step();
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_random(input int n_iter);
        int         g_iter      = -10;
        int         next_decide = 0;
        logic [1:0] g_who = 2'b00, who;
        logic       g_we = 1'b0, last_dbg = 1'b1;
        logic [7:0] g_addr = 8'h00, g_wdata = 8'h00, g_rdata = 8'h00;
        logic [7:0] hold_cpu = 8'h00, hold_dbg = 8'h00, exp_crd, exp_drd;
        logic [1:0] exp_own;
        logic       exp_en, exp_cack, exp_dack, c_want, draining;
        do_reset();
        for (int k = 0; k < n_iter + 20; k++) begin
            draining = (k >= n_iter);
            exp_en   = (k == g_iter + 1);
            exp_own  = (k == g_iter + 1 || k == g_iter + 2) ? g_who : 2'b00;
            exp_cack = (k == g_iter + 2) && (g_who == 2'b01);
            exp_dack = (k == g_iter + 2) && (g_who == 2'b10);
            exp_crd  = (exp_cack && !g_we) ? g_rdata : hold_cpu;
            exp_drd  = (exp_dack && !g_we) ? g_rdata : hold_dbg;
            n_checks++; if (owner !== exp_own) begin n_fail++; $display("[TB] FAIL rnd_owner@%0d: got %b expected %b", k, owner, exp_own); end
            n_checks++; if (mem_en !== exp_en || mem_we !== (exp_en & g_we)) begin n_fail++; $display("[TB] FAIL rnd_strobe@%0d: got en=%b we=%b expected %b/%b", k, mem_en, mem_we, exp_en, exp_en & g_we); end
            if (exp_en) begin
                n_checks++; if (mem_addr !== g_addr || (g_we && mem_wdata !== g_wdata)) begin n_fail++; $display("[TB] FAIL rnd_bus@%0d: got addr=%h wdata=%h expected %h/%h", k, mem_addr, mem_wdata, g_addr, g_wdata); end
            end
            n_checks++; if (cpu_ack !== exp_cack || dbg_ack !== exp_dack) begin n_fail++; $display("[TB] FAIL rnd_ack@%0d: got cpu=%b dbg=%b expected %b/%b", k, cpu_ack, dbg_ack, exp_cack, exp_dack); end
            n_checks++; if (cpu_rdata !== exp_crd) begin n_fail++; $display("[TB] FAIL rnd_cpu_rdata@%0d: got %h expected %h", k, cpu_rdata, exp_crd); end
            n_checks++; if (dbg_rdata !== exp_drd) begin n_fail++; $display("[TB] FAIL rnd_dbg_rdata@%0d: got %h expected %h", k, dbg_rdata, exp_drd); end
            n_checks++; if (cpu_stall !== (cpu_req & ~exp_cack)) begin n_fail++; $display("[TB] FAIL rnd_stall@%0d: got %b expected %b", k, cpu_stall, cpu_req & ~exp_cack); end
            hold_cpu = exp_crd;
            hold_dbg = exp_drd;
            if (exp_cack) begin
                cpu_req = 1'b0;
            end else if (!cpu_req && !draining && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
            end
            if (exp_dack) begin
                dbg_req = 1'b0;
            end else if (!dbg_req && !draining && $urandom_range(0, 2) == 0) begin
                dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 8'($urandom);
            end
            if (draining) dbg_lock = 1'b0;
            else if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
            if (k >= next_decide) begin
                c_want = cpu_req && !dbg_lock;
                if (c_want && (!dbg_req || last_dbg)) who = 2'b01;
                else if (dbg_req)                     who = 2'b10;
                else                                  who = 2'b00;
                if (who != 2'b00) begin
                    g_who = who; g_iter = k; next_decide = k + 3;
                    last_dbg = (who == 2'b10);
                    g_we    = (who == 2'b10) ? dbg_we    : cpu_we;
                    g_addr  = (who == 2'b10) ? dbg_addr  : cpu_addr;
                    g_wdata = (who == 2'b10) ? dbg_wdata : cpu_wdata;
                    if (g_we) shadow[g_addr] = g_wdata;
                    else      g_rdata = shadow[g_addr];
                end
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_dbg_write_read();
        test_round_robin();
        test_lock_stall();
        test_back_to_back();
        test_reset_in_issue();
        test_lock_midflight();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
